joypad_port: RTL and testbench

CPU-bus responder for the two NES controller ports at $4016/$4017. It accepts single-beat read/write requests from the CPU bus, drives the external controller latch and per-port clock lines, and returns serial controller bits as CPU read data. It sits beside the CPU on the system bus, at the opposite end from the bus initiator, and connects directly to the controller connector pins.

---
 rtl/joypad_pkg.sv | 19 +
 rtl/pulse_timer.sv | 28 ++
 rtl/joypad_port.sv | 141 ++++++++++++++
 tb/tb_joypad_port.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/joypad_pkg.sv
// Shared constants, FSM state type and counter sizing for the NES controller port block.
package joypad_pkg;

  localparam logic [15:0] ADDR_PAD1   = 16'h4016;
  localparam logic [15:0] ADDR_PAD2   = 16'h4017;
  localparam logic [2:0]  OPEN_BUS_HI = 3'b010;

  typedef enum logic [1:0] {IDLE, ACK, PULSE, GAP} state_e;

  // Width needed to hold the largest of the three cycle counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter that saturates at zero; done_o is high while the count is zero.
module pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/joypad_port.sv
// CPU-bus responder for the $4016/$4017 controller ports: strobe/latch, per-port shift clocks
// and serial read-back with fixed open-bus upper bits.
module joypad_port
  import joypad_pkg::*;
#(
  parameter int PULSE_CYC = 6,
  parameter int GAP_CYC   = 6,
  parameter int SETUP_CYC = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        r_nw,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        pad_latch,
  output logic [1:0]  pad_clk,
  input  logic [1:0]  pad_data
);

  localparam int          CW       = cnt_width(PULSE_CYC, GAP_CYC, SETUP_CYC);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(SETUP_CYC);

  state_e      state_q, state_d;
  logic        strobe_q, strobe_d;
  logic        port_q, port_d;
  logic        pulse_q, pulse_d;
  logic        ack_q, ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  pad_clk_q, pad_clk_d;
  logic [1:0]  sync1_q, sync2_q;

  logic          hit, accept;
  logic          phase_load, phase_done;
  logic [CW-1:0] phase_val;
  logic          hold_load, hold_done;
  logic          unused_wdata;

  assign unused_wdata = ^wdata[7:1];

  assign hit    = req & ((addr == ADDR_PAD1) | (addr == ADDR_PAD2));
  assign accept = hit & (state_q == IDLE) & hold_done;

  pulse_timer #(.W(CW)) u_phase (
    .clk        (clk),
    .rst        (rst),
    .load_i     (phase_load),
    .load_val_i (phase_val),
    .done_o     (phase_done)
  );

  pulse_timer #(.W(CW)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load_i     (hold_load),
    .load_val_i (HOLD_LD),
    .done_o     (hold_done)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    strobe_d   = strobe_q;
    port_d     = port_q;
    pulse_d    = pulse_q;
    ack_d      = 1'b0;
    rdata_d    = 8'h00;
    phase_load = 1'b0;
    phase_val  = PULSE_LD;
    hold_load  = 1'b0;

    case (state_q)
      IDLE: if (accept) begin
        state_d = ACK;
        ack_d   = 1'b1;
        port_d  = addr[0];
        pulse_d = 1'b0;
        if (r_nw) begin
          rdata_d = {OPEN_BUS_HI, 4'b0000, ~sync2_q[addr[0]]};
          pulse_d = ~strobe_q;
        end else if (!addr[0]) begin
          strobe_d  = wdata[0];
          hold_load = strobe_q & ~wdata[0];
        end
      end
      ACK: begin
        if (pulse_q) begin
          state_d    = PULSE;
          phase_load = 1'b1;
          phase_val  = PULSE_LD;
        end else begin
          state_d = IDLE;
        end
      end
      PULSE: if (phase_done) begin
        state_d    = GAP;
        phase_load = 1'b1;
        phase_val  = GAP_LD;
      end
      GAP: if (phase_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered so the shift clock is glitch-free at the connector.
    pad_clk_d = (state_d == PULSE) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      strobe_q  <= 1'b0;
      port_q    <= 1'b0;
      pulse_q   <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= 8'h00;
      pad_clk_q <= 2'b00;
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
    end else begin
      state_q   <= state_d;
      strobe_q  <= strobe_d;
      port_q    <= port_d;
      pulse_q   <= pulse_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      pad_clk_q <= pad_clk_d;
      sync1_q   <= pad_data;
      sync2_q   <= sync1_q;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign pad_latch = strobe_q;
  assign pad_clk   = pad_clk_q;

endmodule

// File: tb/tb_joypad_port.sv
// Bench for joypad_port: behavioural NES controllers on the pad pins and a transaction-level
// model of acceptance timing, read data and expected shift-clock pulses.
module tb_joypad_port;

  localparam int PULSE_CYC = 6;
  localparam int GAP_CYC   = 6;
  localparam int SETUP_CYC = 12;

  logic        clk = 1'b0;
  logic        rst, req, r_nw;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic        pad_latch;
  logic [1:0]  pad_clk;
  logic [1:0]  pad_data;

  joypad_port #(.PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC), .SETUP_CYC(SETUP_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .r_nw      (r_nw),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .pad_data  (pad_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Two NES controllers: parallel load while latch is high, shift on each pad_clk rise.
  logic [7:0] btn0 = 8'h00, btn1 = 8'h00;
  logic [7:0] sh0 = 8'h00, sh1 = 8'h00;
  logic [1:0] clk_prev = 2'b00;
  always @(posedge clk) begin
    clk_prev <= pad_clk;
    if (pad_latch) begin
      sh0 <= btn0;
      sh1 <= btn1;
    end else begin
      if (pad_clk[0] && !clk_prev[0]) sh0 <= {sh0[6:0], 1'b0};
      if (pad_clk[1] && !clk_prev[1]) sh1 <= {sh1[6:0], 1'b0};
    end
  end
  assign pad_data = ~{sh1[7], sh0[7]};

  // Pulse monitor: counts rises per port, checks each completed high time.
  int pulses[2]  = '{0, 0};
  int width[2]   = '{0, 0};
  int overlap    = 0;
  logic [1:0] mon_prev = 2'b00;
  always @(negedge clk) begin
    if (rst) begin
      width    = '{0, 0};
      mon_prev = 2'b00;
    end else begin
      if (pad_clk == 2'b11) overlap++;
      for (int p = 0; p < 2; p++) begin
        if (pad_clk[p]) begin
          if (!mon_prev[p]) pulses[p]++;
          width[p]++;
        end else if (mon_prev[p]) begin
          check($sformatf("pulse_width_p%0d", p), width[p], PULSE_CYC);
          width[p] = 0;
        end
      end
      mon_prev = pad_clk;
    end
  end

  // Transaction-level reference model.
  bit         strobe_m;
  int         free_at;
  logic [7:0] snap[2];
  int         idx[2];
  int         exp_pulses[2] = '{0, 0};

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_buttons(input logic [7:0] b0, input logic [7:0] b1);
    btn0 = b0;
    btn1 = b1;
    if (strobe_m) begin
      snap[0] = b0;
      snap[1] = b1;
    end
    idle(4);
  endtask

  task automatic do_op(input bit rd, input logic [15:0] a, input logic [7:0] wd, output int lat);
    int c, acc, exp_lat, limit;
    bit hit, got, p, b;
    logic [7:0] exp_rd, got_rd;
    hit = (a == 16'h4016) || (a == 16'h4017);
    @(negedge clk);
    c = cyc;
    req = 1'b1; r_nw = rd; addr = a; wdata = wd;
    acc     = (free_at > c) ? free_at : c;
    exp_lat = acc + 1 - c;
    limit   = hit ? exp_lat + 4 : 30;
    lat = 0; got = 1'b0; got_rd = 8'h00;
    while (!got && lat < limit) begin
      @(posedge clk); #1;
      lat++;
      if (ack) begin
        got    = 1'b1;
        got_rd = rdata;
      end
    end
    req = 1'b0;
    if (!hit) begin
      check("nohit_ack", {31'b0, got}, 0);
      return;
    end
    check("ack_seen", {31'b0, got}, 1);
    check("ack_latency", lat, exp_lat);
    p = a[0];
    if (rd) begin
      if (strobe_m) begin
        b = snap[p][7];
        free_at = acc + 2;
      end else begin
        b = (idx[p] < 8) ? snap[p][7 - idx[p]] : 1'b0;
        if (idx[p] < 8) idx[p]++;
        exp_pulses[p]++;
        free_at = acc + 2 + PULSE_CYC + GAP_CYC;
      end
      exp_rd = {3'b010, 4'b0000, b};
    end else begin
      exp_rd  = 8'h00;
      free_at = acc + 2;
      if (!p) begin
        if (strobe_m && !wd[0] && (acc + 1 + SETUP_CYC > free_at)) free_at = acc + 1 + SETUP_CYC;
        if (wd[0]) begin
          snap[0] = btn0;
          snap[1] = btn1;
          idx     = '{0, 0};
        end
        strobe_m = wd[0];
      end
    end
    if (got) check("rdata", got_rd, exp_rd);
  endtask

  task automatic model_reset();
    strobe_m = 1'b0;
    free_at  = 0;
    idx      = '{0, 0};
    snap[0]  = 8'h00;
    snap[1]  = 8'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1; req = 1'b0; r_nw = 1'b0; addr = 16'h0000; wdata = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, ack}, 0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_pad_latch", {31'b0, pad_latch}, 0);
    check("rst_pad_clk", pad_clk, 2'b00);
    @(negedge clk) rst = 1'b0;

    // Strobe on/off and the read hold-off that follows the falling latch.
    do_op(1'b0, 16'h4016, 8'h01, lat);
    check("latch_high", {31'b0, pad_latch}, 1);
    do_op(1'b0, 16'h4016, 8'h00, lat);
    check("latch_low", {31'b0, pad_latch}, 0);
    do_op(1'b1, 16'h4016, 8'h00, lat);
    check("holdoff_stall", {31'b0, (lat > 12)}, 1);
    idle(14);

    // Serial pattern on port 1: levels 01001101, read back inverted.
    set_buttons(~8'b01001101, 8'h00);
    do_op(1'b0, 16'h4016, 8'h01, lat); idle(3);
    do_op(1'b0, 16'h4016, 8'h00, lat);
    for (int i = 0; i < 8; i++) do_op(1'b1, 16'h4016, 8'h00, lat);
    idle(14);
    check("pattern_pulses_p0", pulses[0], exp_pulses[0]);
    check("pattern_pulses_p1", pulses[1], exp_pulses[1]);

    // Port 2 read with its data line low.
    set_buttons(8'h00, 8'h80);
    do_op(1'b0, 16'h4016, 8'h01, lat); idle(3);
    do_op(1'b0, 16'h4016, 8'h00, lat);
    do_op(1'b1, 16'h4017, 8'h00, lat);
    idle(14);
    check("p2_pulses_p0", pulses[0], exp_pulses[0]);
    check("p2_pulses_p1", pulses[1], exp_pulses[1]);

    // Strobe held high: back-to-back reads, no shift clocks.
    set_buttons(8'h80, 8'h00);
    do_op(1'b0, 16'h4016, 8'h01, lat); idle(3);
    for (int i = 0; i < 3; i++) do_op(1'b1, 16'h4016, 8'h00, lat);
    idle(2);
    check("strobe1_pulses_p0", pulses[0], exp_pulses[0]);

    // Request held through PULSE/GAP, and a decode miss.
    do_op(1'b0, 16'h4016, 8'h00, lat);
    do_op(1'b1, 16'h4016, 8'h00, lat);
    do_op(1'b1, 16'h4016, 8'h00, lat);
    check("held_req_latency", lat, PULSE_CYC + GAP_CYC + 2);
    do_op(1'b0, 16'h4015, 8'h01, lat);
    check("nohit_no_latch", {31'b0, pad_latch}, 0);

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k == 0) begin
        set_buttons(8'($urandom), 8'($urandom));
      end else if (k <= 2) begin
        do_op(1'b0, 16'h4016, 8'($urandom), lat); idle(3);
      end else if (k == 3) begin
        do_op(1'b0, 16'h4017, 8'($urandom), lat);
      end else begin
        do_op(1'b1, ($urandom_range(0, 1) != 0) ? 16'h4017 : 16'h4016, 8'h00, lat);
      end
      idle($urandom_range(0, 3));
    end
    idle(16);
    check("rand_pulses_p0", pulses[0], exp_pulses[0]);
    check("rand_pulses_p1", pulses[1], exp_pulses[1]);
    check("pad_clk_overlap", overlap, 0);

    // Reset in the middle of a shift-clock pulse.
    do_op(1'b0, 16'h4016, 8'h00, lat);
    do_op(1'b1, 16'h4016, 8'h00, lat);
    @(posedge clk); @(posedge clk); #2;
    check("pulse_active", pad_clk, 2'b01);
    rst = 1'b1;
    #1;
    check("midrst_pad_clk", pad_clk, 2'b00);
    check("midrst_ack", {31'b0, ack}, 0);
    check("midrst_rdata", rdata, 8'h00);
    check("midrst_pad_latch", {31'b0, pad_latch}, 0);
    idle(2);
    @(negedge clk) rst = 1'b0;
    model_reset();
    idle(3);
    check("postrst_pad_clk", pad_clk, 2'b00);
    do_op(1'b0, 16'h4016, 8'h01, lat);
    check("postrst_latch", {31'b0, pad_latch}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
